// File: rtl/nibble_add_pkg.sv
// Purpose : shared constants, FSM state type and index-width helper for the nibble-serial adder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Purpose : request/result bundle between a requester and nibble_serial_add_ctrl.
// Latency : n/a (wires only). Optional SignedOverflow exists when SIGNED_OVF_EN is defined.
// Backpressure: Start/Done handshake; Start is ignored while Busy is high.
//   master (requester): drives Start, A, B; observes Busy, Done, Sum, CarryOut.
//   slave  (adder)    : the reverse.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             CarryOut;
`ifdef SIGNED_OVF_EN
    logic             SignedOverflow;

    modport master (output Start, A, B,
                    input  Busy, Done, Sum, CarryOut, SignedOverflow);
    modport slave  (input  Start, A, B,
                    output Busy, Done, Sum, CarryOut, SignedOverflow);
`else
    modport master (output Start, A, B,
                    input  Busy, Done, Sum, CarryOut);
    modport slave  (input  Start, A, B,
                    output Busy, Done, Sum, CarryOut);
`endif
endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Purpose : combinational 4-bit adder slice with carry-in (a, b, cin -> s, cout).
// Latency : zero cycles, purely combinational.
// Backpressure: none.
module nibble_add_slice
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign s     = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Purpose : adds two WIDTH-bit operands through one shared 4-bit slice, LSB nibble first.
// Latency : Done pulses WIDTH/4 cycles after the accepting edge; one op per WIDTH/4+2 cycles.
// Backpressure: Start is sampled only in IDLE; requests while Busy are dropped, not queued.
// Ports   : Clk, Reset (sync, active-high), bus (slave modport: Start/A/B in,
//           Busy/Done/Sum/CarryOut out). Defining SIGNED_OVF_EN adds bus.SignedOverflow.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16    // multiple of 4, at least 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    nibble_serial_add_ctrl_if.slave  bus
);

    localparam int            NIBBLES  = WIDTH / NIBBLE_W;
    localparam int            IW       = idx_w(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_sh, b_sh;     // operands, shifted down one nibble per RUN cycle
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic [IW-1:0]       idx_q;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic                accept;
    logic                last;
    logic                busy;
    logic                done;

    // The low nibble of each shift register is always the nibble at idx_q.
    nibble_add_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SIGNED_OVF_EN
    logic ovf_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            // Shift registers now hold the MSB nibble of each operand.
            ovf_q <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
                     (slice_s[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
        end
    end

    assign bus.SignedOverflow = ovf_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_sh    <= bus.A;
            b_sh    <= bus.B;
            acc     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh    <= a_sh >> NIBBLE_W;
            b_sh    <= b_sh >> NIBBLE_W;
            acc[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_s;
            carry_q <= slice_c;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                // acc has not yet absorbed the final nibble, so splice it in here.
                sum_q  <= {slice_s, acc[WIDTH-NIBBLE_W-1:0]};
                cout_q <= slice_c;
            end
        end
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Sum      = sum_q;
    assign bus.CarryOut = cout_q;

endmodule
